iter_divider: RTL and testbench
===============================

Name: iter_divider

Overview:
Parametrised multi-cycle restoring divider for signed and unsigned division. It is the successor of the fixed 32-bit unsigned load/step datapath.
Control is internal: operands enter through a valid/ready input handshake and results leave through a valid/ready output handshake.
It adds per-operation signed mode, divide-by-zero and overflow handling, and output backpressure. It sits beside the ALU as the shared long-latency divide unit.

Parameters:
WIDTH, 32, operand/result width in bits; legal values are 4 to 64.
CNT_W, $clog2(WIDTH+1), width of the iteration counter. Derived; do not override.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  operands valid
in_ready  out  1  unit can accept operands
dividend  in  WIDTH  dividend
divisor  in  WIDTH  divisor
is_signed  in  1  1 = two's-complement operation, 0 = unsigned
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
quotient  out  WIDTH  quotient
remainder  out  WIDTH  remainder
div_by_zero  out  1  set with the result when divisor was 0
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, active-high):
  - state goes to IDLE.
  - in_ready=1; out_valid, busy, div_by_zero = 0.
  - quotient and remainder = 0; all internal registers cleared.
  - Reset mid-operation abandons the operation. No result is produced.
- FSM states are IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready=1.
  - Acceptance happens on the edge where in_valid && in_ready.
  - On acceptance, latch is_signed and take operand magnitudes. In signed mode, negate negative operands (WIDTH-bit unsigned magnitude). In unsigned mode, use operands as-is.
  - Record neg_q = is_signed & (dividend MSB ^ divisor MSB). Record neg_r = is_signed & dividend MSB.
  - Clear the partial remainder (WIDTH+1 bits) and the count.
  - If divisor==0, go to DONE. Otherwise go to CALC.
- CALC:
  - One quotient bit per cycle, exactly WIDTH cycles.
  - Shift remainder left with the next dividend-magnitude MSB: rs = {rem, dvd_msb}.
  - Compute diff = rs - {0, divisor_mag}.
  - If diff is non-negative: rem = diff and the quotient bit is 1. Otherwise: rem = rs and the quotient bit is 0.
  - On the cycle count reaches WIDTH-1, go to FIX.
- FIX (one cycle):
  - If neg_q, quotient = -q_mag. Otherwise quotient = q_mag.
  - If neg_r, remainder = -r_mag. Otherwise remainder = r_mag.
  - Go to DONE.
- DONE:
  - out_valid=1 and in_ready=0.
  - Outputs are held stable until the edge where out_ready=1; the state then goes to IDLE.
  - out_ready may already be high when DONE is entered; the unit still spends one cycle in DONE.
- Latency:
  - Normal operation: out_valid rises WIDTH+1 cycles after the acceptance edge (33 for WIDTH=32).
  - Divide-by-zero: out_valid rises 1 cycle after acceptance.
  - Throughput is one operation per WIDTH+3 cycles, minimum.
  - in_ready returns the cycle after result handoff. Input and output are not overlapped.
- Divide-by-zero, both modes:
  - quotient = all ones.
  - remainder = dividend, unmodified.
  - div_by_zero=1. The flag is cleared at the next acceptance.
- Signed overflow (most-negative / -1):
  - quotient = most-negative value, remainder = 0, div_by_zero=0.
  - This result falls out of the magnitude path. No special casing is required.
- Sign conventions:
  - Quotient truncates toward zero.
  - Remainder sign follows the dividend; a zero remainder stays 0.
- in_valid outside IDLE is ignored. Operand inputs are sampled only at acceptance.

Test Plan:
- Unsigned basic: is_signed=0, 100/7, WIDTH=32 -> quotient 14, remainder 2, out_valid exactly 33 cycles after acceptance, div_by_zero=0.
- Signed mixed signs: -100/7 -> quotient 0xFFFFFFF2, remainder 0xFFFFFFFE. Also 100/-7 -> quotient 0xFFFFFFF2, remainder 2.
- Divide-by-zero: 0x1234/0 in both modes -> quotient 0xFFFFFFFF, remainder 0x1234, div_by_zero=1, out_valid 1 cycle after acceptance.
- Overflow and unsigned extremes:
  - Signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
  - Unsigned 0xFFFFFFFF/1 -> quotient 0xFFFFFFFF, remainder 0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> outputs and out_valid stable, in_ready=0. Raise out_ready -> IDLE next cycle; a second operation 50/5 returns quotient 10, remainder 0.
- Reset mid-CALC: assert rst at iteration 10 -> all outputs 0, in_ready=1 immediately. A new 9/2 returns quotient 4, remainder 1. Repeat the bench with WIDTH=8 against a random reference model.

Source files
------------

// File: rtl/iter_divider.sv
// iter_divider: multi-cycle restoring divider, signed or unsigned per operation.
// Operands are accepted through a valid/ready handshake. The unit forms one
// quotient bit per cycle from the operand magnitudes, applies the signs in a
// single fix-up cycle, and holds the result until the consumer accepts it.
// WIDTH may be set from 4 to 64. CNT_W is derived from WIDTH and is not meant
// to be overridden.

module iter_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // The count runs 0..WIDTH-1; the last iteration moves the FSM to FIX.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  // Control state and handshake outputs, all registered.
  state_t           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             dbz_q;

  // Datapath. dvd_q starts as the dividend magnitude; each iteration shifts
  // its MSB into the partial remainder and a quotient bit into its LSB, so
  // after WIDTH iterations it holds the quotient magnitude.
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH:0]   rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;

  // Combinational helpers.
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dsr_mag;
  logic [WIDTH+1:0] rs;
  logic [WIDTH+1:0] diff;
  logic [WIDTH:0]   rem_d;
  logic [WIDTH-1:0] dvd_d;
  logic             q_bit;

  // Operand magnitudes taken at acceptance; in signed mode a negative operand
  // is negated into its WIDTH-bit unsigned magnitude (the most-negative value
  // maps onto itself, which is the correct magnitude read as unsigned).
  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    dvd_mag = dividend;
    dsr_mag = divisor;
    if (is_signed && dividend[WIDTH-1]) dvd_mag = -dividend;
    if (is_signed && divisor[WIDTH-1])  dsr_mag = -divisor;
  end

  // One restoring step: shift in the next dividend bit, trial-subtract the
  // divisor, keep the difference only when it is non-negative. rs is kept one
  // bit wider than the remainder so the sign of diff is exact.
  always_comb begin
    rs    = {rem_q, dvd_q[WIDTH-1]};
    diff  = rs - {2'b00, dsr_q};
    q_bit = 1'b0;
    rem_d = rs[WIDTH:0];
    if (!diff[WIDTH+1]) begin
      q_bit = 1'b1;
      rem_d = diff[WIDTH:0];
    end
    dvd_d = {dvd_q[WIDTH-2:0], q_bit};
  end

  // Control FSM with registered outputs and the iterative datapath.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side below reads the value from before this clock edge.
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      dbz_q       <= 1'b0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            neg_quo_q  <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_rem_q  <= is_signed & dividend[WIDTH-1];
            dvd_q      <= dvd_mag;
            dsr_q      <= dsr_mag;
            rem_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (divisor == '0) begin
              // Divide-by-zero skips the iterations: all-ones quotient and
              // the raw dividend as remainder, in either mode.
              quotient_q  <= '1;
              remainder_q <= dividend;
              dbz_q       <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              dbz_q   <= 1'b0;
              state_q <= CALC;
            end
          end
        end

        CALC: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) state_q <= FIX;
        end

        FIX: begin
          // Quotient truncates toward zero; remainder takes the dividend's
          // sign, and negating a zero remainder leaves it zero.
          quotient_q  <= neg_quo_q ? -dvd_q : dvd_q;
          remainder_q <= neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end

        DONE: begin
          // Result is held until the consumer takes it; even if out_ready is
          // already high, at least one cycle is spent here.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end

        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
  assign div_by_zero = dbz_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;

endmodule

// File: tb/tb_iter_divider.sv
// tb_iter_divider: directed checks on a 32-bit divider followed by directed
// extremes and random operations on an 8-bit divider. Expected results come
// from a behavioural reference (native integer / and %) pushed to a
// scoreboard when operands are driven and popped when the result is handed off.

module tb_iter_divider;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // 32-bit instance
  logic        a_in_valid, a_in_ready, a_is_signed, a_out_valid, a_out_ready;
  logic        a_dbz, a_busy;
  logic [31:0] a_dividend, a_divisor, a_quotient, a_remainder;

  // 8-bit instance
  logic        b_in_valid, b_in_ready, b_is_signed, b_out_valid, b_out_ready;
  logic        b_dbz, b_busy;
  logic [7:0]  b_dividend, b_divisor, b_quotient, b_remainder;

  iter_divider #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .dividend(a_dividend), .divisor(a_divisor), .is_signed(a_is_signed),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .quotient(a_quotient), .remainder(a_remainder),
    .div_by_zero(a_dbz), .busy(a_busy)
  );

  iter_divider #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .dividend(b_dividend), .divisor(b_divisor), .is_signed(b_is_signed),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .quotient(b_quotient), .remainder(b_remainder),
    .div_by_zero(b_dbz), .busy(b_busy)
  );

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } exp_t;

  typedef struct packed {
    logic        out_valid;
    logic        in_ready;
    logic        busy;
    logic        dbz;
    logic [31:0] q;
    logic [31:0] r;
  } outs_t;

  exp_t scb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic longint sext(input logic [63:0] v, input int w);
    logic signed [63:0] t;
    t = v << (64 - w);
    return t >>> (64 - w);
  endfunction

  // Behavioural reference: native truncating division on sign-extended values.
  function automatic exp_t ref_div(input int w, input logic [31:0] a,
                                   input logic [31:0] b, input logic s);
    logic [63:0] mask, au, bu, qq, rr;
    longint      sa, sd;
    exp_t        e;
    mask = (64'd1 << w) - 64'd1;
    au   = {32'd0, a} & mask;
    bu   = {32'd0, b} & mask;
    if (bu == 64'd0) begin
      qq = mask;
      rr = au;
      e.dbz = 1'b1;
    end else if (s) begin
      sa = sext(au, w);
      sd = sext(bu, w);
      qq = 64'(sa / sd);
      rr = 64'(sa % sd);
      e.dbz = 1'b0;
    end else begin
      qq = au / bu;
      rr = au % bu;
      e.dbz = 1'b0;
    end
    e.q = 32'(qq & mask);
    e.r = 32'(rr & mask);
    return e;
  endfunction

  task automatic drive_in(input bit w32, input logic v, input logic [31:0] a,
                          input logic [31:0] b, input logic s);
    if (w32) begin
      a_in_valid = v; a_dividend = a; a_divisor = b; a_is_signed = s;
    end else begin
      b_in_valid = v; b_dividend = a[7:0]; b_divisor = b[7:0]; b_is_signed = s;
    end
  endtask

  task automatic set_ready(input bit w32, input logic r);
    if (w32) a_out_ready = r;
    else     b_out_ready = r;
  endtask

  function automatic outs_t snap(input bit w32);
    outs_t o;
    if (w32) begin
      o = {a_out_valid, a_in_ready, a_busy, a_dbz, a_quotient, a_remainder};
    end else begin
      o = {b_out_valid, b_in_ready, b_busy, b_dbz, {24'd0, b_quotient}, {24'd0, b_remainder}};
    end
    return o;
  endfunction

  // One full operation: accept, wait for the result, check it while it is
  // held for 'hold' cycles (or with out_ready already high when 'early'),
  // then hand it off and check the return to idle.
  task automatic op(input bit w32, input logic [31:0] a, input logic [31:0] b,
                    input logic s, input int hold, input bit early, input string tag);
    int    w, lat, n, exp_lat;
    outs_t o;
    exp_t  e;
    w = w32 ? 32 : 8;
    e = ref_div(w, a, b, s);
    scb.push_back(e);
    // Normal results rise WIDTH+1 edges after the acceptance edge; a
    // divide-by-zero result is already visible in the cycle right after it.
    exp_lat = e.dbz ? 0 : w + 1;

    n = 0;
    o = snap(w32);
    while (!o.in_ready && n < 100) begin
      @(posedge clk); #1; o = snap(w32); n++;
    end
    check({tag, "/in_ready_idle"}, 64'(o.in_ready), 64'd1);

    drive_in(w32, 1'b1, a, b, s);
    set_ready(w32, early);
    @(posedge clk); #1;
    // Scrambled operands after acceptance must not affect the result.
    drive_in(w32, 1'b0, ~a, ~b, ~s);

    lat = 0;
    o = snap(w32);
    while (!o.out_valid && lat < 200) begin
      @(posedge clk); #1; lat++; o = snap(w32);
    end
    check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "/quotient"}, 64'(o.q), 64'(scb[0].q));
    check({tag, "/remainder"}, 64'(o.r), 64'(scb[0].r));
    check({tag, "/div_by_zero"}, 64'(o.dbz), 64'(scb[0].dbz));
    check({tag, "/busy_in_ready"}, {62'd0, o.busy, o.in_ready}, 64'd2);

    if (!early) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1; o = snap(w32);
        check({tag, "/held"},
              {o.out_valid, o.in_ready, o.q, o.r},
              {1'b1, 1'b0, scb[0].q, scb[0].r});
      end
      set_ready(w32, 1'b1);
    end

    @(posedge clk); #1;
    e = scb.pop_front();
    o = snap(w32);
    check({tag, "/handoff"}, {61'd0, o.out_valid, o.in_ready, o.busy}, 64'b010);
    set_ready(w32, 1'b0);
  endtask

  // Global watchdog so the run can never hang.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    outs_t o;
    logic [31:0] ra, rb;

    rst = 1'b1;
    drive_in(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    drive_in(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    a_out_ready = 1'b0;
    b_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    o = snap(1'b1);
    check("reset32", 64'(o), 64'({1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0}));
    o = snap(1'b0);
    check("reset8", 64'(o), 64'({1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0}));
    rst = 1'b0;
    @(posedge clk); #1;

    // 32-bit directed operations
    op(1'b1, 32'd100,        32'd7,          1'b0, 0,  1'b0, "u_100_7");
    op(1'b1, -32'sd100,      32'd7,          1'b1, 0,  1'b0, "s_m100_7");
    op(1'b1, 32'd100,        -32'sd7,        1'b1, 0,  1'b0, "s_100_m7");
    op(1'b1, 32'h1234,       32'd0,          1'b0, 0,  1'b0, "u_dbz");
    op(1'b1, 32'h1234,       32'd0,          1'b1, 0,  1'b0, "s_dbz");
    op(1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 0,  1'b0, "s_overflow");
    op(1'b1, 32'hFFFF_FFFF,  32'd1,          1'b0, 0,  1'b0, "u_max_1");
    op(1'b1, -32'sd6,        32'd3,          1'b1, 0,  1'b0, "s_zero_rem");
    op(1'b1, -32'sd7,        32'd2,          1'b1, 0,  1'b1, "s_early_ready");
    op(1'b1, 32'd1000,       32'd3,          1'b0, 10, 1'b0, "backpressure");
    op(1'b1, 32'd50,         32'd5,          1'b0, 0,  1'b0, "after_bp");

    // Reset in the middle of CALC abandons the operation.
    drive_in(1'b1, 1'b1, 32'h1234_5678, 32'd3, 1'b0);
    @(posedge clk); #1;
    drive_in(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    o = snap(1'b1);
    check("midcalc_reset", 64'(o), 64'({1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0}));
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    o = snap(1'b1);
    check("no_result_after_reset", {62'd0, o.out_valid, o.busy}, 64'd0);
    op(1'b1, 32'd9, 32'd2, 1'b0, 0, 1'b0, "u_9_2");

    // 8-bit directed extremes
    op(1'b0, 32'h80, 32'hFF, 1'b1, 0, 1'b0, "w8_s_overflow");
    op(1'b0, 32'hFF, 32'h01, 1'b0, 0, 1'b0, "w8_u_max_1");
    op(1'b0, 32'hFF, 32'hFF, 1'b0, 0, 1'b0, "w8_u_max_max");
    op(1'b0, 32'h7F, 32'h80, 1'b1, 0, 1'b0, "w8_s_max_min");
    op(1'b0, 32'h00, 32'h05, 1'b1, 0, 1'b0, "w8_zero_dvd");
    op(1'b0, 32'h87, 32'h00, 1'b1, 1, 1'b0, "w8_s_dbz");

    // 8-bit random operations
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      op(1'b0, ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
         ($urandom_range(0, 3) == 0), "w8_rand");
    end

    check("scoreboard_empty", 64'(scb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
